// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state type, skid depth and parity helper for fifo_burst_drain
package fifo_drain_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} drain_state_t;

  localparam int SKID_DEPTH   = 2;
  localparam int PARITY_MAX_W = 256;

  // Callers zero-extend their word to PARITY_MAX_W; padding does not change the XOR.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry arrival-ordered push/pop buffer with occupancy count
module skid_buf2
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail;
  logic             do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count <= 2'(SKID_DEPTH));

endmodule

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - drains a 1-cycle-latency FIFO into a fixed-length burst stream
// Optional even-parity sideband output enabled by FIFO_BURST_DRAIN_PARITY_EN.
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef FIFO_BURST_DRAIN_PARITY_EN
  ,
  output logic             m_parity
`endif
);

`ifdef FIFO_BURST_DRAIN_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int BUF_W = WIDTH + PAR_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  drain_state_t     state;
  logic             inflight;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] fetch_cnt;
  logic [1:0]       buf_count;
  logic [BUF_W-1:0] push_word;
  logic [BUF_W-1:0] head;
  logic             accept;
  logic             fetch_allowed;
  logic             credit_ok;

  assign accept        = m_valid && m_ready;
  assign m_valid       = (buf_count != 2'd0);
  assign m_data        = head[WIDTH-1:0];
  assign m_last        = m_valid && (beat_cnt == LAST_IDX);
  assign fetch_allowed = (fetch_cnt != '0) || en;

  // The slot freed by this cycle's pop is credited so a steady stream runs gap-free.
  assign credit_ok  = ({1'b0, buf_count} + {2'b00, inflight}) < (3'(SKID_DEPTH) + {2'b00, accept});
  assign fifo_rd_en = rst && !fifo_empty && credit_ok && fetch_allowed;

  assign busy = (state == BURST) || inflight || (buf_count != 2'd0) || (fetch_cnt != '0);

`ifdef FIFO_BURST_DRAIN_PARITY_EN
  assign push_word = {even_parity(PARITY_MAX_W'(fifo_data)), fifo_data};
  assign m_parity  = head[WIDTH];
`else
  assign push_word = fifo_data;
`endif

  skid_buf2 #(.WIDTH(BUF_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_word),
    .pop       (accept),
    .head      (head),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      beat_cnt  <= '0;
      fetch_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        fetch_cnt <= (fetch_cnt == LAST_IDX) ? '0 : fetch_cnt + CNT_W'(1);
      end
      if (accept) begin
        beat_cnt <= m_last ? '0 : beat_cnt + CNT_W'(1);
      end
      case (state)
        IDLE:    if (accept && (beat_cnt == '0) && (BURST_LEN > 1)) state <= BURST;
        BURST:   if (accept && m_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - directed self-checking bench for fifo_burst_drain (BURST_LEN=4)
module tb_fifo_burst_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
`ifdef FIFO_BURST_DRAIN_PARITY_EN
  logic       m_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  logic [7:0] got_data [$];
  logic       got_last [$];
  int         got_cyc  [$];
  int         cyc          = 0;
  int         rd_total     = 0;
  int         acc_total    = 0;
  int         first_rd_cyc = -1;

  always #5 clk = ~clk;

  fifo_burst_drain #(.WIDTH(8), .BURST_LEN(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_BURST_DRAIN_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  // FIFO model: data appears the cycle after the read enable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      if (rd_total == 0) first_rd_cyc = cyc;
      rd_total++;
    end
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
      got_cyc.push_back(cyc);
      acc_total++;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = base + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_arrived"}, 32'(got_data.size() >= n), 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] base, input int n);
    check({tag, "_count"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check({tag, "_data"}, 32'(got_data[i]), 32'(base + 8'(i)));
      check({tag, "_last"}, 32'(got_last[i]), 32'((i % 4) == 3));
    end
  endtask

  initial begin
    int rd_base;
    int k;

    // Reset with data already waiting in the FIFO.
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    load(8'h11, 8);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    check("rd_after_rst", 32'(fifo_rd_en), 32'd1);

    // Streaming: 8 beats, last on every 4th, one beat per cycle.
    wait_beats("stream", 8, 40);
    repeat (3) tick();
    check_stream("stream", 8'h11, 8);
    if (got_cyc.size() >= 8) begin
      check("stream_latency", 32'(got_cyc[0]), 32'(first_rd_cyc + 2));
      for (int i = 1; i < 8; i++) check("stream_gap", 32'(got_cyc[i]), 32'(got_cyc[0] + i));
    end
    check("stream_idle_busy", 32'(busy), 32'd0);
    check("stream_idle_valid", 32'(m_valid), 32'd0);

    // Backpressure for 5 cycles after two accepted beats.
    clear_got();
    load(8'h21, 8);
    wait_beats("bp_pre", 2, 20);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_hold_data", 32'(m_data), 32'h23);
      check("bp_hold_last", 32'(m_last), 32'd0);
      check("bp_outstanding", 32'((rd_total - acc_total) <= 2), 32'd1);
      tick();
    end
    m_ready = 1'b1;
    wait_beats("bp_post", 8, 40);
    repeat (4) tick();
    check_stream("bp", 8'h21, 8);
    check("bp_busy", 32'(busy), 32'd0);

    // en dropped after the second read of a burst.
    clear_got();
    en = 1'b0;
    load(8'h31, 8);
    tick();
    check("en_low_no_rd", 32'(fifo_rd_en), 32'd0);
    rd_base = rd_total;
    en = 1'b1;
    k = 0;
    while ((rd_total - rd_base) < 2 && k < 20) begin
      tick();
      k++;
    end
    en = 1'b0;
    repeat (20) tick();
    check("en_drop_reads", 32'(rd_total - rd_base), 32'd4);
    check_stream("en_drop", 8'h31, 4);
    check("en_drop_busy", 32'(busy), 32'd0);
    check("en_drop_rd_en", 32'(fifo_rd_en), 32'd0);
    en = 1'b1;
    wait_beats("en_resume", 8, 40);
    repeat (4) tick();
    check_stream("en_resume", 8'h31, 8);
    check("en_resume_reads", 32'(rd_total - rd_base), 32'd8);

    // Underrun after two beats of a burst.
    clear_got();
    load(8'h41, 2);
    wait_beats("ur_pre", 2, 20);
    repeat (4) tick();
    check("ur_valid", 32'(m_valid), 32'd0);
    check("ur_busy", 32'(busy), 32'd1);
    check("ur_last", 32'(m_last), 32'd0);
    load(8'h43, 2);
    wait_beats("ur_post", 4, 20);
    repeat (3) tick();
    check_stream("ur", 8'h41, 4);
    check("ur_done_busy", 32'(busy), 32'd0);

`ifdef FIFO_BURST_DRAIN_PARITY_EN
    m_ready = 1'b0;
    load(8'h07, 1);
    load(8'h03, 1);
    k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    repeat (2) tick();
    check("par_data0", 32'(m_data), 32'h07);
    check("par_bit0", 32'(m_parity), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("par_data1", 32'(m_data), 32'h03);
    check("par_bit1", 32'(m_parity), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
